// File: rtl/wb_drain_ctrl.sv
// Write-back buffer drain controller.
// Takes the head entry of the write-back buffer and issues word-aligned,
// byte-masked write beats. Cachable entries go to the data-cache port and
// non-cachable entries go to the memory port. An access that straddles a word
// boundary becomes two beats. The entry is popped on the final beat's ack.
module wb_drain_ctrl #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en_vld,
  input  logic [ADDR_W-1:0]   i_en_addr,
  input  logic [DATA_W-1:0]   i_en_data,
  input  logic [2:0]          i_en_size,
  input  logic                i_cachable,
  output logic                o_read,
  output logic                o_dc_req,
  output logic [ADDR_W-1:0]   o_dc_addr,
  output logic [DATA_W-1:0]   o_dc_wdata,
  output logic [DATA_W/8-1:0] o_dc_bmask,
  input  logic                i_dc_ack,
  output logic                o_mem_req,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  input  logic                i_mem_ack,
  output logic                o_busy,
  output logic                o_err
);

  localparam int BM_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT1 = 2'd1;
  localparam logic [1:0] S_BEAT2 = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  logic [1:0]        state_q,  state_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] data_q,   data_d;
  logic [2:0]        size_q,   size_d;
  logic              cach_q,   cach_d;
  logic [ADDR_W-1:0] oaddr_q,  oaddr_d;
  logic [DATA_W-1:0] owdata_q, owdata_d;
  logic [BM_W-1:0]   obmask_q, obmask_d;

  // Byte-lane mask spanning both beats: size ones shifted up by the offset.
  function automatic logic [7:0] mask8(input logic [2:0] size, input logic [1:0] off);
    logic [7:0] m;
    m = (8'd1 << size) - 8'd1;
    return m << off;
  endfunction

  // True when the access runs past the end of its word.
  function automatic logic split_needed(input logic [2:0] size, input logic [1:0] off);
    return ({2'b00, off} + {1'b0, size}) > 4'd4;
  endfunction

  // In IDLE the beat values are derived from the live entry (for the capture
  // edge); in any other state they come from the captured copy.
  logic              in_idle;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [2:0]        sel_size;
  logic [1:0]        sel_off;
  logic [7:0]        m8;
  logic [4:0]        shamt_lo;
  logic [5:0]        shamt_hi;
  logic [DATA_W-1:0] wd_lo;
  logic [DATA_W-1:0] wd_hi;
  logic              split;
  logic              legal;
  logic              ack;
  logic              req_active;

  // Beat formation and handshake decode.
  always_comb begin
    in_idle    = (state_q == S_IDLE);
    sel_addr   = in_idle ? i_en_addr : addr_q;
    sel_data   = in_idle ? i_en_data : data_q;
    sel_size   = in_idle ? i_en_size : size_q;
    sel_off    = sel_addr[1:0];
    m8         = mask8(sel_size, sel_off);
    shamt_lo   = {sel_off, 3'b000};
    shamt_hi   = 6'd32 - {1'b0, shamt_lo};
    wd_lo      = sel_data << shamt_lo;
    wd_hi      = sel_data >> shamt_hi;
    split      = split_needed(sel_size, sel_off);
    legal      = (sel_size != 3'd0) && (sel_size <= 3'd4);
    ack        = cach_q ? i_dc_ack : i_mem_ack;
    req_active = (state_q == S_BEAT1) || (state_q == S_BEAT2);
  end

  // Next-state, capture and pop logic.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    size_d   = size_q;
    cach_d   = cach_q;
    oaddr_d  = oaddr_q;
    owdata_d = owdata_q;
    obmask_d = obmask_q;
    o_read   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_en_vld) begin
          if (legal) begin
            addr_d   = i_en_addr;
            data_d   = i_en_data;
            size_d   = i_en_size;
            cach_d   = i_cachable;
            oaddr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
            owdata_d = wd_lo;
            obmask_d = m8[3:0];
            state_d  = S_BEAT1;
          end else begin
            state_d  = S_DROP;
          end
        end
      end
      S_BEAT1: begin
        if (ack) begin
          if (split) begin
            oaddr_d  = oaddr_q + ADDR_W'(4);
            owdata_d = wd_hi;
            obmask_d = m8[7:4];
            state_d  = S_BEAT2;
          end else begin
            o_read   = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_BEAT2: begin
        if (ack) begin
          o_read  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        o_read  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and captured-entry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      size_q   <= '0;
      cach_q   <= 1'b0;
      oaddr_q  <= '0;
      owdata_q <= '0;
      obmask_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      size_q   <= size_d;
      cach_q   <= cach_d;
      oaddr_q  <= oaddr_d;
      owdata_q <= owdata_d;
      obmask_q <= obmask_d;
    end
  end

  // Both ports share the beat registers; only the selected port's req rises.
  always_comb begin
    o_dc_req    = req_active & cach_q;
    o_mem_req   = req_active & ~cach_q;
    o_dc_addr   = oaddr_q;
    o_dc_wdata  = owdata_q;
    o_dc_bmask  = obmask_q;
    o_mem_addr  = oaddr_q;
    o_mem_wdata = owdata_q;
    o_mem_bmask = obmask_q;
    o_busy      = (state_q != S_IDLE);
    o_err       = (state_q == S_DROP);
  end

endmodule
